// File: rtl/mul_pkg.sv
// Shared definitions for the scalar/vector multiplier-sharing controller.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } mul_state_e;

  typedef enum logic {
    OwnScl = 1'b0,
    OwnVec = 1'b1
  } owner_e;

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-way round-robin arbiter; req[0] is the scalar port, req[1] the vector port.
module mul_rr_arb2
  import mul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] grant
);

  owner_e last_grant_q, last_grant_d;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant_q == OwnVec) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (adv && grant[1]) begin
      last_grant_d = OwnVec;
    end else if (adv && grant[0]) begin
      last_grant_d = OwnScl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OwnVec;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle multiplier between the scalar EX stage and the vector unit.
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             s_req_valid,
  input  logic [XLEN-1:0]  s_op_a,
  input  logic [XLEN-1:0]  s_op_b,
  input  logic [1:0]       s_mul_op,
  input  logic             s_kill,
  output logic             s_req_ready,
  output logic             s_stall,
  output logic             s_resp_valid,
  output logic [XLEN-1:0]  s_res,
  input  logic             v_req_valid,
  input  logic [XLEN-1:0]  v_op_a,
  input  logic [XLEN-1:0]  v_op_b,
  input  logic [1:0]       v_mul_op,
  input  logic [TAG_W-1:0] v_tag,
  output logic             v_req_ready,
  output logic             v_resp_valid,
  input  logic             v_resp_ready,
  output logic [XLEN-1:0]  v_res,
  output logic [TAG_W-1:0] v_resp_tag,
  output logic             m_start,
  output logic [XLEN-1:0]  m_op_a,
  output logic [XLEN-1:0]  m_op_b,
  output logic [1:0]       m_op,
  input  logic             m_done,
  input  logic [XLEN-1:0]  m_res
);

  mul_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             killed_q, killed_d;
  logic [XLEN-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       req, grant;
  logic             grant_en;

  assign req      = {v_req_valid, s_req_valid & ~s_kill};
  assign grant_en = (state_q == StIdle) & ~rst;

  mul_rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (rst),
    .req   (req),
    .adv   (m_start),
    .grant (grant)
  );

  always_comb begin
    s_req_ready  = grant_en & grant[0];
    v_req_ready  = grant_en & grant[1];
    m_start      = s_req_ready | v_req_ready;
    // The multiplier sees the grant mux in the start cycle, the latched copy afterwards.
    m_op_a       = s_req_ready ? s_op_a   : (v_req_ready ? v_op_a   : op_a_q);
    m_op_b       = s_req_ready ? s_op_b   : (v_req_ready ? v_op_b   : op_b_q);
    m_op         = s_req_ready ? s_mul_op : (v_req_ready ? v_mul_op : op_q);
    s_resp_valid = (state_q == StResp) & (owner_q == OwnScl) & ~killed_q;
    v_resp_valid = (state_q == StResp) & (owner_q == OwnVec);
    s_stall      = s_req_valid & ~s_resp_valid & ~s_kill;
    s_res        = res_q;
    v_res        = res_q;
    v_resp_tag   = tag_q;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_d     = op_q;
    tag_d    = tag_q;
    res_d    = res_q;
    unique case (state_q)
      StIdle: begin
        if (m_start) begin
          op_a_d   = m_op_a;
          op_b_d   = m_op_b;
          op_d     = m_op;
          owner_d  = v_req_ready ? OwnVec : OwnScl;
          tag_d    = v_req_ready ? v_tag : tag_q;
          killed_d = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // A killed scalar op still runs to completion; only its response is dropped.
        if (owner_q == OwnScl && s_kill) begin
          killed_d = 1'b1;
        end
        if (m_done) begin
          res_d   = m_res;
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_q == OwnScl || v_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= OwnScl;
      killed_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
    end
  end

endmodule
